// File: rtl/hazard_ctrl_unit_if.sv
// Hazard controller bundle: pipeline-side indices/flags in, stage enables,
// flushes, forwarding selects and performance counters out.
interface hazard_ctrl_if #(
    parameter int NUM_SRC    = 2,
    parameter int REG_ADDR_W = 5
);
    logic [NUM_SRC*REG_ADDR_W-1:0] rs_ID;
    logic [NUM_SRC-1:0]            rsuse_ID;
    logic                          branch_taken_ID;
    logic [REG_ADDR_W-1:0]         rd_EXE;
    logic                          regwrite_EXE;
    logic                          memread_EXE;
    logic                          mc_start_EXE;
    logic [REG_ADDR_W-1:0]         rd_MEM;
    logic                          regwrite_MEM;
    logic                          memread_MEM;

    logic                          PC_EN_IF;
    logic                          reg_FD_EN;
    logic                          reg_DE_EN;
    logic                          reg_EM_EN;
    logic                          reg_MW_EN;
    logic                          reg_FD_flush;
    logic                          reg_DE_flush;
    logic                          reg_EM_flush;
    logic [NUM_SRC*2-1:0]          forward_ctrl;
    logic [31:0]                   stall_cycles;
    logic [31:0]                   flush_count;

    // Pipeline side: supplies stage information, consumes control.
    modport master (
        output rs_ID, rsuse_ID, branch_taken_ID,
        output rd_EXE, regwrite_EXE, memread_EXE, mc_start_EXE,
        output rd_MEM, regwrite_MEM, memread_MEM,
        input  PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN,
        input  reg_FD_flush, reg_DE_flush, reg_EM_flush,
        input  forward_ctrl, stall_cycles, flush_count
    );

    // Hazard unit side.
    modport slave (
        input  rs_ID, rsuse_ID, branch_taken_ID,
        input  rd_EXE, regwrite_EXE, memread_EXE, mc_start_EXE,
        input  rd_MEM, regwrite_MEM, memread_MEM,
        output PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN,
        output reg_FD_flush, reg_DE_flush, reg_EM_flush,
        output forward_ctrl, stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage core: per-operand forwarding, load-use
// bubble, taken-branch flush and a multi-cycle EXE hold FSM.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters;
// without it both counter outputs read zero.
module hazard_ctrl_unit #(
    parameter int NUM_SRC    = 2,
    parameter int MC_CYCLES  = 4,
    parameter int REG_ADDR_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hz
);
    localparam int CNT_W = ($clog2(MC_CYCLES) < 1) ? 1 : $clog2(MC_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_CYCLES - 2);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MC_BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SRC-1:0] exe_match_s;
    logic [NUM_SRC-1:0] mem_match_s;
    logic               mc_hold_s;
    logic               load_use_s;
    logic [NUM_SRC*2-1:0] fwd_s;
    logic pc_en_s, fd_en_s, de_en_s, em_en_s, mw_en_s;
    logic fd_flush_s, de_flush_s, em_flush_s;

    // Register index 0 is hard-wired zero, so it never produces a match.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_match
        logic [REG_ADDR_W-1:0] rs_s;
        assign rs_s = hz.rs_ID[g*REG_ADDR_W +: REG_ADDR_W];
        assign exe_match_s[g] = hz.rsuse_ID[g] && (rs_s != {REG_ADDR_W{1'b0}}) &&
                                hz.regwrite_EXE && (rs_s == hz.rd_EXE);
        assign mem_match_s[g] = hz.rsuse_ID[g] && (rs_s != {REG_ADDR_W{1'b0}}) &&
                                hz.regwrite_MEM && (rs_s == hz.rd_MEM);
    end

    assign mc_hold_s  = ((state_q == ST_MC_BUSY) && (cnt_q != {CNT_W{1'b0}})) ||
                        ((state_q == ST_IDLE) && hz.mc_start_EXE);
    assign load_use_s = (|exe_match_s) && hz.memread_EXE;

    // FSM state register: phase and remaining hold cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: load the hold count on entry, count down, release at zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (hz.mc_start_EXE) begin
                    state_d = ST_MC_BUSY;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end
            end
            ST_MC_BUSY: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    state_d = ST_MC_BUSY;
                    cnt_d   = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Per-operand forwarding select, EXE result preferred over MEM.
    always_comb begin
        fwd_s = {(NUM_SRC*2){1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!rst_n) begin
                fwd_s[2*i +: 2] = 2'b00;
            end else if (exe_match_s[i] && !hz.memread_EXE && !mc_hold_s) begin
                fwd_s[2*i +: 2] = 2'b01;
            end else if (mem_match_s[i]) begin
                fwd_s[2*i +: 2] = hz.memread_MEM ? 2'b11 : 2'b10;
            end else begin
                fwd_s[2*i +: 2] = 2'b00;
            end
        end
    end

    // Stage control: MC hold beats load-use, which beats the branch flush.
    always_comb begin
        pc_en_s    = 1'b1;
        fd_en_s    = 1'b1;
        de_en_s    = 1'b1;
        em_en_s    = 1'b1;
        mw_en_s    = 1'b1;
        fd_flush_s = 1'b0;
        de_flush_s = 1'b0;
        em_flush_s = 1'b0;
        if (!rst_n) begin
            pc_en_s = 1'b1;
        end else if (mc_hold_s) begin
            pc_en_s    = 1'b0;
            fd_en_s    = 1'b0;
            de_en_s    = 1'b0;
            em_flush_s = 1'b1;
        end else if (load_use_s) begin
            pc_en_s    = 1'b0;
            fd_en_s    = 1'b0;
            de_flush_s = 1'b1;
        end else if (hz.branch_taken_ID) begin
            fd_flush_s = 1'b1;
        end else begin
            fd_flush_s = 1'b0;
        end
    end

    assign hz.PC_EN_IF     = pc_en_s;
    assign hz.reg_FD_EN    = fd_en_s;
    assign hz.reg_DE_EN    = de_en_s;
    assign hz.reg_EM_EN    = em_en_s;
    assign hz.reg_MW_EN    = mw_en_s;
    assign hz.reg_FD_flush = fd_flush_s;
    assign hz.reg_DE_flush = de_flush_s;
    assign hz.reg_EM_flush = em_flush_s;
    assign hz.forward_ctrl = fwd_s;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    // Saturating counts of front-end stall cycles and IF/ID flush cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            if (!pc_en_s && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (fd_flush_s && (flush_count_q != 32'hFFFF_FFFF)) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign hz.stall_cycles = stall_cycles_q;
    assign hz.flush_count  = flush_count_q;
`else
    assign hz.stall_cycles = 32'd0;
    assign hz.flush_count  = 32'd0;
`endif
endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Next-generation hazard controller for the 5-stage core (IF/ID/EXE/MEM/WB).
- Generalised to NUM_SRC source operands per ID instruction, with independent forwarding selects per operand.
- Detects load-use hazards and injects a one-cycle bubble; flushes IF/ID on a taken branch resolved in ID.
- Adds a counter-driven FSM that holds the front of the pipeline while a multi-cycle EXE operation (mul/div) completes.

Parameters:
- NUM_SRC, 2, number of source operands checked per ID instruction (1..3)
- MC_CYCLES, 4, total EXE occupancy of a multi-cycle op in cycles (>=2)
- REG_ADDR_W, 5, register index width

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- rs_ID  in  NUM_SRC*REG_ADDR_W  packed source indices; operand i at [i*REG_ADDR_W +: REG_ADDR_W]
- rsuse_ID  in  NUM_SRC  operand i is actually read
- branch_taken_ID  in  1  branch resolved taken in ID
- rd_EXE  in  REG_ADDR_W  EXE destination
- regwrite_EXE  in  1  EXE writes rd_EXE
- memread_EXE  in  1  EXE instruction is a load
- mc_start_EXE  in  1  EXE instruction is multi-cycle
- rd_MEM  in  REG_ADDR_W  MEM destination
- regwrite_MEM  in  1  MEM writes rd_MEM
- memread_MEM  in  1  MEM instruction is a load
- PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN  out  1 each  stage enables
- reg_FD_flush, reg_DE_flush, reg_EM_flush  out  1 each  bubble insert
- forward_ctrl  out  NUM_SRC*2  per-operand select, operand i at [2i+1:2i]

Behaviour:
- Reset (rst_n=0, async): state=IDLE, cnt=0. All EN=1, all flush=0, forward_ctrl=0 while reset is held.
- Outputs are combinational from inputs, state and cnt. Only state and cnt are registered.
- Match rule per operand i: rsuse_ID[i] & rs_i!=0 & regwrite_X & rs_i==rd_X.
- Forward select, priority EXE over MEM:
  - EXE match & !memread_EXE & !mc_hold -> 01
  - else MEM match -> 11 if memread_MEM, else 10
  - else 00
- mc_hold = (state==MC_BUSY & cnt!=0) | (state==IDLE & mc_start_EXE).
- Load-use: any operand with EXE match & memread_EXE.
  - Response: PC_EN_IF=0, reg_FD_EN=0, reg_DE_flush=1 for exactly one cycle.
  - Next cycle the load is in MEM and forward select 11 applies.
- Stall (front hold): PC_EN_IF=0, reg_FD_EN=0, reg_DE_EN=0, reg_EM_flush=1. reg_MW_EN stays 1 so MEM/WB drain.
- FSM states IDLE, MC_BUSY:
  - IDLE & mc_start_EXE: stall this cycle; next state MC_BUSY, cnt<=MC_CYCLES-2.
  - MC_BUSY & cnt!=0: stall; cnt<=cnt-1.
  - MC_BUSY & cnt==0: release cycle. No MC stall, mc_start_EXE ignored, EM captures result; next state IDLE.
  - Stall cycles per multi-cycle op = MC_CYCLES-1. MC_CYCLES=2 gives one stall then release.
- Priority: MC stall > load-use > branch flush.
  - Branch is honoured only when neither stall applies; then reg_FD_flush=1 for one cycle.
  - A suppressed branch is re-evaluated by ID in the next unstalled cycle.
- mc_start_EXE during MC_BUSY (held instruction) never re-triggers.
- Back-to-back multi-cycle op entering EXE right after the release cycle starts a fresh sequence from IDLE.
- Operand index 0 never matches. The same source in multiple operands yields identical selects.
- Reset asserted mid-MC_BUSY: immediate return to IDLE; first cycle after deassert has no stall.
- cnt width = $clog2(MC_CYCLES), minimum 1.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - Outputs stall_cycles[31:0] counts cycles with PC_EN_IF=0.
  - Outputs flush_count[31:0] counts cycles with reg_FD_flush=1.
  - Both saturate at 32'hFFFFFFFF and reset to 0 asynchronously.
- Undefined: both ports exist and are tied to 0, with no counter flops.

Test Plan:
- rs_ID={x2,x1}, rsuse=2'b11, rd_EXE=1 (regwrite, no load), rd_MEM=2 (regwrite, no load) -> forward_ctrl=4'b1001, no stall, all EN=1.
- Load to x5 in EXE; ID uses x5 on operand 1 -> cycle t: PC_EN_IF=0, reg_FD_EN=0, reg_DE_flush=1. Cycle t+1: operand-1 select=11, no stall.
- MC_CYCLES=4, mc_start_EXE at t, held high -> stall at t, t+1, t+2; release at t+3 (all EN=1, flush=0); state IDLE at t+4.
- branch_taken_ID during load-use cycle -> reg_FD_flush=0 that cycle. Branch reasserted next cycle -> reg_FD_flush=1.
- rst_n dropped at MC_BUSY with cnt=1 -> outputs immediately EN=1/flush=0. After deassert, first cycle shows no stall with mc_start_EXE=0.
- HAZARD_PERF_CNT_EN, run the MC_CYCLES=4 op plus one taken branch -> stall_cycles=3, flush_count=1.
